ramp_phase_source: RTL and testbench



---
 rtl/ramp_phase_source_pkg.sv | 12 +
 rtl/ramp_phase_source_if.sv | 10 +
 rtl/ramp_phase_source_phase_accumulator.sv | 51 +++++
 rtl/ramp_phase_source.sv | 67 ++++++
 tb/tb_ramp_phase_source.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ramp_phase_source_pkg.sv
// ramp_phase_source_pkg: shared ramper state encodings, controller states and default widths
package ramp_phase_source_pkg;
  localparam int PHASE_WIDTH_DEF = 48;
  localparam int CNT_WIDTH_DEF = 32;
  typedef enum logic [1:0] {
    RAMP_NORMAL = 2'b00,
    RAMP_DONE   = 2'b01,
    RAMP_UP     = 2'b10,
    RAMP_DOWN   = 2'b11
  } ramp_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REQ, ST_DONE} state_t;
endpackage

// File: rtl/ramp_phase_source_if.sv
// ramp_phase_source_if: AXI-Stream phase channel towards the ramper
interface ramp_phase_source_if #(
  parameter int PHASE_WIDTH = ramp_phase_source_pkg::PHASE_WIDTH_DEF
) ();
  logic [PHASE_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, tvalid, input tready);
  modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/ramp_phase_source_phase_accumulator.sv
// phase_accumulator: phase register with carry-synchronous increment reload and offset output stage
module phase_accumulator
  import ramp_phase_source_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_start,
  input  logic [PHASE_WIDTH-1:0] i_inc,
  input  logic [PHASE_WIDTH-1:0] i_off,
  input  logic                   i_tready,
  output logic [PHASE_WIDTH-1:0] o_tdata,
  output logic                   o_tvalid,
  output logic                   o_wrap
);
  logic [PHASE_WIDTH-1:0] r_acc, r_inc, w_sum, w_acc_next;
  logic w_carry, w_fire;
  always_comb begin
    w_fire = o_tvalid & i_tready;
    {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_inc};
    w_acc_next = w_fire ? w_sum : r_acc;
  end
  // the increment only changes on a carry so every period is run at a single frequency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_inc <= '0;
      o_tdata <= '0;
      o_tvalid <= 1'b0;
      o_wrap <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      o_tdata <= '0;
      o_tvalid <= 1'b0;
      o_wrap <= 1'b0;
    end else if (i_start) begin
      r_acc <= '0;
      r_inc <= i_inc;
      o_tdata <= i_off;
      o_tvalid <= 1'b1;
      o_wrap <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      if (w_fire && w_carry) r_inc <= i_inc;
      o_wrap <= w_fire & w_carry;
      if (i_tready) o_tdata <= w_acc_next + i_off;
    end
  end
endmodule

// File: rtl/ramp_phase_source.sv
// ramp_phase_source: DDS phase source with period counting and ramp-down handshake to the ramper
module ramp_phase_source
  import ramp_phase_source_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_off,
  input  logic [CNT_WIDTH-1:0]   cfg_periods,
  input  logic                   ramp_down_req,
  input  logic [1:0]             ramp_state,
  ramp_phase_source_if.master    m_axis_phase,
  output logic                   start_ramp_down,
  output logic                   wrap,
  output logic [CNT_WIDTH-1:0]   period_count,
  output logic                   done
);
  state_t r_state;
  logic w_cnt_inc, w_trig, w_start, w_clr;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  always_comb begin
    w_clr = !enable;
    w_start = enable && r_state == ST_IDLE;
    w_cnt_inc = wrap && ramp_state == RAMP_NORMAL && period_count != '1;
    w_cnt_next = period_count + CNT_WIDTH'(w_cnt_inc);
    w_trig = ramp_down_req || (cfg_periods != '0 && w_cnt_next >= cfg_periods);
  end
  phase_accumulator #(.PHASE_WIDTH(PHASE_WIDTH)) u_acc (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (w_clr),
    .i_start (w_start),
    .i_inc   (cfg_phase_inc),
    .i_off   (cfg_phase_off),
    .i_tready(m_axis_phase.tready),
    .o_tdata (m_axis_phase.tdata),
    .o_tvalid(m_axis_phase.tvalid),
    .o_wrap  (wrap)
  );
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_state <= ST_IDLE;
      start_ramp_down <= 1'b0;
      done <= 1'b0;
      period_count <= '0;
    end else begin
      period_count <= w_cnt_next;
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN: if (w_trig) begin
          r_state <= ST_REQ;
          start_ramp_down <= 1'b1;
        end
        ST_REQ: if (ramp_state == RAMP_DONE) begin
          r_state <= ST_DONE;
          start_ramp_down <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ramp_phase_source.sv
// tb_ramp_phase_source: scoreboard bench for the phase stream and ramp-down protocol
module tb_ramp_phase_source;
  logic clk = 1'b0;
  logic reset, enable, ramp_down_req;
  logic [47:0] cfg_inc, cfg_off;
  logic [31:0] cfg_periods, period_count;
  logic [1:0] ramp_state;
  logic start_ramp_down, wrap, done;
  ramp_phase_source_if #(.PHASE_WIDTH(48)) axis ();
  ramp_phase_source dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_phase_inc(cfg_inc), .cfg_phase_off(cfg_off),
    .cfg_periods(cfg_periods), .ramp_down_req(ramp_down_req), .ramp_state(ramp_state),
    .m_axis_phase(axis), .start_ramp_down(start_ramp_down), .wrap(wrap),
    .period_count(period_count), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {logic [47:0] d; logic w;} beat_t;
  beat_t q[$];
  logic [47:0] m_acc, m_inc;
  logic m_carry;
  int n_vec = 0, n_err = 0;

  task automatic push_beats(input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.d = m_acc + cfg_off;
      e.w = m_carry;
      q.push_back(e);
      {m_carry, m_acc} = {1'b0, m_acc} + {1'b0, m_inc};
      if (m_carry) m_inc = cfg_inc;
    end
  endtask

  task automatic step(input logic ready);
    @(negedge clk);
    if (q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard empty at %0t", $time);
    end else begin
      n_vec++;
      if (axis.tvalid !== 1'b1) begin n_err++; $display("FAIL tvalid got %b want 1", axis.tvalid); end
      n_vec++;
      if (axis.tdata !== q[0].d) begin n_err++; $display("FAIL tdata got %h want %h", axis.tdata, q[0].d); end
      n_vec++;
      if (wrap !== q[0].w) begin n_err++; $display("FAIL wrap got %b want %b at %0t", wrap, q[0].w, $time); end
      if (ready) void'(q.pop_front());
      else q[0].w = 1'b0;
    end
    axis.tready = ready;
  endtask

  task automatic go(input logic [47:0] inc, input logic [47:0] off);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    cfg_inc = inc;
    cfg_off = off;
    enable = 1'b1;
    axis.tready = 1'b1;
    m_acc = '0; m_inc = inc; m_carry = 1'b0;
    q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; ramp_down_req = 1'b0; axis.tready = 1'b0;
    cfg_inc = '0; cfg_off = '0; cfg_periods = '0; ramp_state = 2'b00;
    repeat (3) @(negedge clk);
    n_vec++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL reset tvalid got %b want 0", axis.tvalid); end
    n_vec++; if (axis.tdata !== 48'h0) begin n_err++; $display("FAIL reset tdata got %h want 0", axis.tdata); end
    n_vec++; if ({wrap, start_ramp_down, done} !== 3'b000) begin n_err++; $display("FAIL reset flags got %b want 000", {wrap, start_ramp_down, done}); end
    n_vec++; if (period_count !== 32'h0) begin n_err++; $display("FAIL reset count got %0d want 0", period_count); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL idle tvalid got %b want 0", axis.tvalid); end
  endtask

  task automatic test_stream;
    cfg_periods = '0; ramp_state = 2'b10;
    go(48'h1000_0000_0000, 48'h0);
    push_beats(40);
    repeat (40) step(1'b1);
    n_vec++; if (period_count !== 32'h0) begin n_err++; $display("FAIL rampup count got %0d want 0", period_count); end
    n_vec++; if (start_ramp_down !== 1'b0) begin n_err++; $display("FAIL stream start got %b want 0", start_ramp_down); end
  endtask

  task automatic test_stall;
    push_beats(10);
    repeat (3) step(1'b1);
    repeat (3) step(1'b0);
    repeat (7) step(1'b1);
  endtask

  task automatic test_freq_change;
    cfg_inc = 48'h2000_0000_0003;
    push_beats(40);
    repeat (40) step(1'b1);
  endtask

  task automatic test_auto;
    int exp;
    cfg_periods = 32'd3; ramp_state = 2'b00;
    go(48'h1000_0000_0000, 48'hF123_4567_89AB);
    push_beats(60);
    for (int k = 0; k < 50; k++) begin
      step(1'b1);
      exp = (k > 16) + (k > 32) + (k > 48);
      n_vec++; if (period_count !== 32'(exp)) begin n_err++; $display("FAIL auto count k=%0d got %0d want %0d", k, period_count, exp); end
      n_vec++; if (start_ramp_down !== (k >= 49)) begin n_err++; $display("FAIL auto start k=%0d got %b want %b", k, start_ramp_down, k >= 49); end
    end
    ramp_state = 2'b11;
    step(1'b1);
    step(1'b1);
    ramp_state = 2'b01;
    n_vec++; if ({start_ramp_down, done} !== 2'b10) begin n_err++; $display("FAIL pre-done start/done got %b want 10", {start_ramp_down, done}); end
    step(1'b1);
    n_vec++; if ({start_ramp_down, done} !== 2'b01) begin n_err++; $display("FAIL done start/done got %b want 01", {start_ramp_down, done}); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({axis.tvalid, wrap, start_ramp_down, done} !== 4'b0000) begin n_err++; $display("FAIL midreset flags got %b want 0000", {axis.tvalid, wrap, start_ramp_down, done}); end
    n_vec++; if (axis.tdata !== 48'h0 || period_count !== 32'h0) begin n_err++; $display("FAIL midreset data/count got %h/%0d want 0/0", axis.tdata, period_count); end
    reset = 1'b0;
    m_acc = '0; m_inc = cfg_inc; m_carry = 1'b0;
    q.delete();
    push_beats(5);
    repeat (5) step(1'b1);
  endtask

  task automatic test_manual_stop;
    cfg_periods = '0; ramp_state = 2'b00;
    go(48'h1000_0000_0000, 48'h0000_0000_0100);
    push_beats(22);
    repeat (20) step(1'b1);
    n_vec++; if (period_count !== 32'd1) begin n_err++; $display("FAIL manual count got %0d want 1", period_count); end
    ramp_down_req = 1'b1;
    step(1'b1);
    ramp_down_req = 1'b0;
    n_vec++; if (start_ramp_down !== 1'b1) begin n_err++; $display("FAIL manual start got %b want 1", start_ramp_down); end
    enable = 1'b0;
    @(negedge clk);
    n_vec++; if ({axis.tvalid, start_ramp_down} !== 2'b00) begin n_err++; $display("FAIL stop tvalid/start got %b want 00", {axis.tvalid, start_ramp_down}); end
    n_vec++; if (period_count !== 32'h0) begin n_err++; $display("FAIL stop count got %0d want 0", period_count); end
    q.delete();
  endtask

  task automatic test_no_auto;
    cfg_periods = '0; ramp_state = 2'b00;
    go(48'h8000_0000_0000, 48'h0);
    push_beats(202);
    for (int k = 0; k < 202; k++) begin
      step(1'b1);
      n_vec++; if (start_ramp_down !== 1'b0) begin n_err++; $display("FAIL noauto start k=%0d got %b want 0", k, start_ramp_down); end
    end
    n_vec++; if (period_count !== 32'd100) begin n_err++; $display("FAIL noauto count got %0d want 100", period_count); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_freq_change;
    test_auto;
    test_reset_mid;
    test_manual_stop;
    test_no_auto;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
